// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timing constants and serializer state encoding
package uart_pkg;

  localparam int CYCLE_1S   = 50_000_000;
  localparam int BAUDRATE   = 115_200;
  // 50 MHz / 115200 rounded down to a whole cycle count per bit
  localparam int CYCLE_UART = 434;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte write handshake between a producer and the UART transmitter
interface uart_tx_fifo_if;

  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;

  modport master (
    output wr_data,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    output wr_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with an explicit occupancy register
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is decided from the registered count only, so a pop in the same
  // cycle never opens room for a push into a full FIFO.
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy independently.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int CYCLE_BIT = CYCLE_UART,
  parameter  int DEPTH     = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 res,
  uart_tx_fifo_if.slave        wr,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [AW:0]          count
);

  localparam int            CW       = (CYCLE_BIT > 1) ? $clog2(CYCLE_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLE_BIT - 1);

  tx_state_t     state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          pop;
  logic [7:0]    pop_data;
  logic          full;
  logic          empty;
  logic          bit_end;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .res       (res),
    .push      (wr.wr_valid),
    .push_data (wr.wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign wr.wr_ready = !full;
  assign busy        = (state != ST_IDLE) || !empty;
  assign bit_end     = (cyc == CYC_LAST);

  // Serializer registers; the pin itself is a flop so it never glitches and
  // returns high the moment reset is asserted.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= ST_IDLE;
      cyc     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      cyc     <= cyc_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      uart_tx <= tx_n;
    end
  end

  // Next-state logic; tx_n is the line level for the cycle after the edge,
  // which lets a pop and the falling start edge land on the same clock.
  always_comb begin
    state_n   = state;
    cyc_n     = cyc;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = 1'b1;
    pop       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = pop_data;
          cyc_n   = '0;
          state_n = ST_START;
          tx_n    = 1'b0;
        end
      end

      ST_START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          cyc_n     = '0;
          bit_idx_n = '0;
          state_n   = ST_DATA;
          tx_n      = shift[0];
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end

      ST_DATA: begin
        tx_n = shift[bit_idx];
        if (bit_end) begin
          cyc_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = ST_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift[bit_idx + 3'd1];
          end
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end

      ST_STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          cyc_n = '0;
          if (!empty) begin
            // Back-to-back frame: straight into the next start bit.
            pop     = 1'b1;
            shift_n = pop_data;
            state_n = ST_START;
            tx_n    = 1'b0;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  localparam int CB    = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          uart_tx;
  logic          busy;
  logic [AW:0]   count;

  uart_tx_fifo_if wr_if ();

  uart_tx_fifo #(
    .CYCLE_BIT (CB),
    .DEPTH     (DEPTH)
  ) dut (
    .clk     (clk),
    .res     (res),
    .wr      (wr_if),
    .uart_tx (uart_tx),
    .busy    (busy),
    .count   (count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int idx         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples mid-bit and records each received byte and frame start cycle.
  logic [7:0] rxq[$];
  int         startq[$];
  int         stop_err = 0;
  bit         mon_act  = 1'b0;
  int         mon_cnt  = 0;
  logic [7:0] mon_sh   = 8'h00;

  always @(negedge clk) begin
    if (res) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (uart_tx === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
        startq.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt >= CB + CB / 2 && mon_cnt < 9 * CB && (mon_cnt % CB) == CB / 2)
        mon_sh = {uart_tx, mon_sh[7:1]};
      if (mon_cnt == 9 * CB + CB / 2 && uart_tx !== 1'b1)
        stop_err++;
      if (mon_cnt == 10 * CB - 1) begin
        rxq.push_back(mon_sh);
        mon_act = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [7:0] bytes[$], input int budget, output bit ok);
    int  i;
    int  n;
    bit  acc;
    i = 0;
    n = 0;
    while (i < bytes.size() && n < budget) begin
      wr_if.wr_data  = bytes[i];
      wr_if.wr_valid = 1'b1;
      acc = wr_if.wr_ready;
      step();
      if (acc) i++;
      n++;
    end
    wr_if.wr_valid = 1'b0;
    ok = (i == bytes.size());
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    ok = (busy === 1'b0);
    repeat (4) step();
  endtask

  task automatic clear_mon();
    rxq.delete();
    startq.delete();
    stop_err = 0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (2) step();
    vectors += 4;
    if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_uart_tx got=%b exp=1", uart_tx); end
    if (wr_if.wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready got=%b exp=1", wr_if.wr_ready); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
    res = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic       exp;
    bit         ok;
    b = 8'h61;
    clear_mon();
    wr_if.wr_data  = b;
    wr_if.wr_valid = 1'b1;
    step();
    wr_if.wr_valid = 1'b0;
    vectors += 3;
    if (count !== 5'd1) begin miscompares++; $display("FAIL single_count_after_push got=%0d exp=1", count); end
    if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_after_push got=%b exp=1", uart_tx); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_after_push got=%b exp=1", busy); end
    step();
    vectors++;
    if (count !== 5'd0) begin miscompares++; $display("FAIL single_count_after_pop got=%0d exp=0", count); end
    for (int j = 0; j < 10 * CB; j++) begin
      if (j < CB) exp = 1'b0;
      else if (j < 9 * CB) exp = b[(j - CB) / CB];
      else exp = 1'b1;
      vectors++;
      if (uart_tx !== exp) begin miscompares++; $display("FAIL single_line cycle=%0d got=%b exp=%b", j, uart_tx, exp); end
      if (j == 10 * CB - 1) begin
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_last_cycle got=%b exp=1", busy); end
      end
      step();
    end
    vectors += 2;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_end got=%b exp=1", uart_tx); end
    wait_idle(10, ok);
    vectors++;
    if (rxq.size() != 1 || rxq[0] !== b) begin
      miscompares++;
      $display("FAIL single_decode got_n=%0d got=%h exp=%h", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx, b);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[$];
    bit ok_push, ok_idle;
    clear_mon();
    bytes = '{8'h61, 8'h62, 8'h63};
    push_seq(bytes, 10, ok_push);
    wait_idle(400, ok_idle);
    vectors += 3;
    if (!ok_push || !ok_idle) begin miscompares++; $display("FAIL b2b_timeout push=%0d idle=%0d exp=1,1", ok_push, ok_idle); end
    if (rxq.size() != 3) begin miscompares++; $display("FAIL b2b_count got=%0d exp=3", rxq.size()); end
    if (stop_err != 0) begin miscompares++; $display("FAIL b2b_stop_bits got=%0d exp=0", stop_err); end
    for (int i = 0; i < 3 && i < rxq.size(); i++) begin
      vectors++;
      if (rxq[i] !== bytes[i]) begin miscompares++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, rxq[i], bytes[i]); end
    end
    for (int i = 1; i < 3 && i < startq.size(); i++) begin
      vectors++;
      if (startq[i] - startq[i-1] != 10 * CB) begin
        miscompares++;
        $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, startq[i] - startq[i-1], 10 * CB);
      end
    end
  endtask

  task automatic test_full();
    int n;
    bit acc;
    clear_mon();
    idx = 0;
    n   = 0;
    while (wr_if.wr_ready === 1'b1 && n < 100) begin
      wr_if.wr_data  = idx[7:0];
      wr_if.wr_valid = 1'b1;
      acc = wr_if.wr_ready;
      step();
      if (acc) idx++;
      n++;
    end
    wr_if.wr_data = idx[7:0];
    vectors += 3;
    if (wr_if.wr_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got=%b exp=0", wr_if.wr_ready); end
    if (idx != 17) begin miscompares++; $display("FAIL full_accepted got=%0d exp=17", idx); end
    if (count !== 5'd16) begin miscompares++; $display("FAIL full_count got=%0d exp=16", count); end
  endtask

  task automatic test_collision();
    int n;
    bit acc;
    bit ok;
    n = 0;
    while (count === 5'd16 && n < 100) begin
      acc = wr_if.wr_ready;
      step();
      if (acc) idx++;
      n++;
    end
    vectors += 3;
    if (count !== 5'd15) begin miscompares++; $display("FAIL collide_count_after_pop got=%0d exp=15", count); end
    if (wr_if.wr_ready !== 1'b1) begin miscompares++; $display("FAIL collide_ready got=%b exp=1", wr_if.wr_ready); end
    if (idx != 17) begin miscompares++; $display("FAIL collide_refused got=%0d exp=17", idx); end
    acc = wr_if.wr_ready;
    step();
    if (acc) idx++;
    vectors += 2;
    if (count !== 5'd16) begin miscompares++; $display("FAIL collide_count_refill got=%0d exp=16", count); end
    if (idx != 18) begin miscompares++; $display("FAIL collide_accepted got=%0d exp=18", idx); end
    n = 0;
    while (idx < 20 && n < 200) begin
      wr_if.wr_data  = idx[7:0];
      wr_if.wr_valid = 1'b1;
      acc = wr_if.wr_ready;
      step();
      if (acc) idx++;
      n++;
    end
    wr_if.wr_valid = 1'b0;
    wait_idle(1500, ok);
    vectors += 2;
    if (!ok) begin miscompares++; $display("FAIL full_drain_timeout busy=%b exp=0", busy); end
    if (rxq.size() != 20) begin miscompares++; $display("FAIL full_rx_count got=%0d exp=20", rxq.size()); end
    for (int i = 0; i < 20 && i < rxq.size(); i++) begin
      vectors++;
      if (rxq[i] !== i[7:0]) begin miscompares++; $display("FAIL full_order byte%0d got=%h exp=%h", i, rxq[i], i[7:0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes[$];
    bit ok;
    int bad;
    clear_mon();
    bytes = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    push_seq(bytes, 10, ok);
    repeat (13) step();
    vectors += 2;
    if (count !== 5'd5) begin miscompares++; $display("FAIL rstmid_queued got=%0d exp=5", count); end
    if (uart_tx !== 1'b0) begin miscompares++; $display("FAIL rstmid_bit3 got=%b exp=0", uart_tx); end
    #2 res = 1'b1;
    #1;
    vectors += 4;
    if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx_async got=%b exp=1", uart_tx); end
    if (count !== 5'd0) begin miscompares++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    if (wr_if.wr_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got=%b exp=1", wr_if.wr_ready); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    #3 res = 1'b0;
    bad = 0;
    for (int j = 0; j < 100; j++) begin
      step();
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    vectors += 2;
    if (bad != 0) begin miscompares++; $display("FAIL rstmid_idle_after got=%0d bad cycles exp=0", bad); end
    if (rxq.size() != 0) begin miscompares++; $display("FAIL rstmid_no_frames got=%0d exp=0", rxq.size()); end
  endtask

  task automatic test_wrap();
    logic [7:0] bytes[$];
    bit ok_push, ok_idle;
    int v;
    clear_mon();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      v = i * 37 + 5;
      bytes.push_back(v[7:0]);
    end
    push_seq(bytes, 3000, ok_push);
    wait_idle(1500, ok_idle);
    vectors += 3;
    if (!ok_push || !ok_idle) begin miscompares++; $display("FAIL wrap_timeout push=%0d idle=%0d exp=1,1", ok_push, ok_idle); end
    if (rxq.size() != 3 * DEPTH) begin miscompares++; $display("FAIL wrap_count got=%0d exp=%0d", rxq.size(), 3 * DEPTH); end
    if (stop_err != 0) begin miscompares++; $display("FAIL wrap_stop_bits got=%0d exp=0", stop_err); end
    for (int i = 0; i < 3 * DEPTH && i < rxq.size(); i++) begin
      vectors++;
      if (rxq[i] !== bytes[i]) begin miscompares++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, rxq[i], bytes[i]); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    wr_if.wr_data  = 8'h00;
    wr_if.wr_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_collision();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- FIFO-buffered 8N1 UART transmitter. It accepts bytes from an upstream producer over a valid/ready handshake and serializes them onto the board's PMOD TX pin.
- It replaces the free-running inline serializer in the character generator, so the generator only produces bytes and never handles bit timing.
- It sits between any byte source (chargen, echo logic) and the uart_tx top-level pin.

Parameters:
- CYCLE_BIT, 434, clock cycles per UART bit (50 MHz / 115200, integer); must be >= 2
- DEPTH, 16, FIFO depth in bytes; power of two, >= 2
- AW, $clog2(DEPTH), FIFO pointer width (derived, not overridden)

Ports:
- clk  input  1  system clock, 50 MHz
- res  input  1  asynchronous reset, active-high
- wr_data  input  8  byte to enqueue
- wr_valid  input  1  producer offers wr_data this cycle
- wr_ready  output  1  FIFO can accept a byte (= not full)
- uart_tx  output  1  serial line; idle high
- busy  output  1  frame in progress or FIFO non-empty
- count  output  AW+1  bytes currently held in FIFO (excludes the byte being shifted)

Behaviour:
- Clock and reset: one clock, clk. Reset res is asynchronous and active-high.
- Reset values: uart_tx=1, wr_ready=1, busy=0, count=0, FIFO pointers 0, FSM=IDLE, bit counter 0.
- Reset asserted mid-frame: uart_tx goes high immediately (asynchronously), the frame is aborted, and FIFO contents are discarded.
- Push: occurs on a rising edge when wr_valid && wr_ready. wr_ready = (count != DEPTH), combinational from count.
- Full FIFO: no push is accepted, even if a pop happens in the same cycle. The producer must hold wr_valid and wr_data until wr_ready.
- Pop: occurs only from the FSM, as below.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers: wrap modulo DEPTH. count is a separate register, not derived from the pointers.
- FSM states: IDLE, START, DATA, STOP. A cycle counter runs 0..CYCLE_BIT-1; a bit index runs 0..7.
- IDLE: uart_tx=1. If count != 0, pop the head into the shift register, go to START, and clear the cycle counter.
- START: uart_tx=0 for CYCLE_BIT cycles, then go to DATA with bit index 0.
- DATA: uart_tx = shift[bit index], LSB first, each bit held CYCLE_BIT cycles. After bit 7, go to STOP.
- STOP: uart_tx=1 for CYCLE_BIT cycles. At the end of STOP:
  - if count != 0, pop and go directly to START (back-to-back frames, no extra idle cycle);
  - otherwise go to IDLE.
- Latency: byte pushed at edge N into an empty FIFO with the FSM in IDLE → popped at edge N+1 → uart_tx low from edge N+1.
- Frame length: exactly 10*CYCLE_BIT cycles. With continuous data, throughput is one byte per 10*CYCLE_BIT cycles.
- uart_tx is driven from a flop (no combinational glitches on the pin).
- busy = (state != IDLE) || (count != 0).
- No parity, no break generation, no flow control.

Decomposition:
- Shared package (uart_pkg):
  - constants CYCLE_1S=50_000_000, BAUDRATE=115200, CYCLE_UART=434;
  - FSM state encoding for IDLE, START, DATA, STOP.
- One sub-module, sync_fifo: parameterized WIDTH/DEPTH, push/pop/full/empty/count, same clk/res.
- uart_tx_fifo instantiates sync_fifo and contains the serializer FSM.

Test Plan:
- Single byte (sim CYCLE_BIT=4): push 0x61 into an empty FIFO at edge N → uart_tx low at N+1 for 4 cycles, then 1,0,0,0,0,1,1,0 (LSB first), each 4 cycles, then high for 4. busy falls at frame end; count 1→0 at N+1.
- Back-to-back: push 0x61, 0x62, 0x63 on consecutive cycles → three contiguous 40-cycle frames with no idle gap; decoded bytes match in order.
- Full: hold wr_valid with 0x00..0x13 while DEPTH=16 → wr_ready drops when count=16 (first byte already popped, so 17 accepted). Stalled bytes are not lost; all 20 appear on the line in order.
- Push/pop collision: FIFO full, end of STOP pops while wr_valid=1 → push refused that cycle and count goes 16→15. Next cycle the push is accepted and count returns to 16.
- Reset mid-frame: assert res during DATA bit 3 with 5 bytes queued → uart_tx=1 asynchronously, count=0, wr_ready=1. After release, with no new pushes, the line stays idle high.
- Wrap-around: push/pop 3*DEPTH bytes → pointer wrap produces no corruption; a scoreboard compares every decoded byte.
